// File: rtl/ibex_pkg.sv
// Shared types for the instruction fetch bus responder.
// Response payload and bus error cause encoding.
package ibex_pkg;

    typedef enum logic [1:0] {
        BusErrNone       = 2'd0,
        BusErrMisaligned = 2'd1,
        BusErrOutOfRange = 2'd2
    } bus_err_e;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } instr_rsp_t;

    function automatic bus_err_e bus_err_cause(
        input logic [31:0] addr,
        input logic [32:0] mem_bytes
    );
        bus_err_e cause;
        cause = BusErrNone;
        if (addr[1:0] != 2'b00) begin
            cause = BusErrMisaligned;
        end else if ({1'b0, addr} >= mem_bytes) begin
            cause = BusErrOutOfRange;
        end
        bus_err_cause = cause;
    endfunction

endpackage

// File: rtl/ibex_fixed_latency_pipe.sv
// Fixed-depth valid/payload shift register for fetch responses.
// Payload is zeroed whenever its valid bit is clear.
module ibex_fixed_latency_pipe
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid,
    input  instr_rsp_t in_rsp,
    output logic       out_valid,
    output instr_rsp_t out_rsp
);

    logic [Depth-1:0] valid_q;
    instr_rsp_t       rsp_q [Depth];

    // Shift entries one stage per cycle; stage 0 loads at the grant edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                rsp_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            rsp_q[0]   <= in_valid ? in_rsp : '0;
            for (int i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
                rsp_q[i]   <= rsp_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[Depth-1];
    assign out_rsp   = rsp_q[Depth-1];

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// Memory end of the core instruction fetch bus.
// Fixed-latency in-order responses with preload side port.
module ibex_instr_mem_responder
    import ibex_pkg::*;
#(
    parameter int unsigned MemSizeWords   = 1024,
    parameter int unsigned ReadLatency    = 1,
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned AW            = $clog2(MemSizeWords)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    input  logic          stall_i,
    input  logic          load_we_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [31:0]   load_wdata_i,
    output logic          busy_o
);

    localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);
    localparam logic [32:0] MemBytes = 33'(MemSizeWords) << 2;

    logic [31:0]   mem_q [MemSizeWords];
    logic [CntW-1:0] count_q;
    logic          full;
    bus_err_e      err_cause;
    instr_rsp_t    req_rsp;
    instr_rsp_t    pipe_rsp;
    logic          pipe_valid;

    // Preload port; reads in the same cycle see the old word.
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem_q[load_addr_i] <= load_wdata_i;
        end
    end

    assign full        = (count_q == CntW'(MaxOutstanding)) & ~pipe_valid;
    assign instr_gnt_o = instr_req_i & ~stall_i & ~full;
    assign err_cause   = bus_err_cause(instr_addr_i, MemBytes);

    // Build the response for the address presented this cycle.
    always_comb begin
        req_rsp       = '0;
        req_rsp.err   = (err_cause != BusErrNone);
        req_rsp.rdata = req_rsp.err ? 32'h0 : mem_q[instr_addr_i[AW+1:2]];
    end

    ibex_fixed_latency_pipe #(
        .Depth (ReadLatency)
    ) u_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (instr_gnt_o),
        .in_rsp    (req_rsp),
        .out_valid (pipe_valid),
        .out_rsp   (pipe_rsp)
    );

    // Track granted-but-unanswered requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            unique case ({instr_gnt_o, pipe_valid})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign instr_rvalid_o = pipe_valid;
    assign instr_rdata_o  = pipe_rsp.rdata;
    assign instr_err_o    = pipe_rsp.err;
    assign busy_o         = (count_q != '0);

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Directed bench for the fetch bus responder.
// Instance a: ReadLatency=1; instance b: ReadLatency=3.
module tb_ibex_instr_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_req, a_gnt, a_rvalid, a_err;
    logic        a_stall, a_we, a_busy;
    logic [31:0] a_addr, a_rdata, a_wdata;
    logic [9:0]  a_laddr;

    logic        b_rst_n, b_req, b_gnt, b_rvalid, b_err;
    logic        b_stall, b_we, b_busy;
    logic [31:0] b_addr, b_rdata, b_wdata;
    logic [9:0]  b_laddr;

    ibex_instr_mem_responder #(
        .MemSizeWords   (1024),
        .ReadLatency    (1),
        .MaxOutstanding (2)
    ) u_dut_a (
        .clk_i          (clk),
        .rst_ni         (a_rst_n),
        .instr_req_i    (a_req),
        .instr_addr_i   (a_addr),
        .instr_gnt_o    (a_gnt),
        .instr_rvalid_o (a_rvalid),
        .instr_rdata_o  (a_rdata),
        .instr_err_o    (a_err),
        .stall_i        (a_stall),
        .load_we_i      (a_we),
        .load_addr_i    (a_laddr),
        .load_wdata_i   (a_wdata),
        .busy_o         (a_busy)
    );

    ibex_instr_mem_responder #(
        .MemSizeWords   (1024),
        .ReadLatency    (3),
        .MaxOutstanding (2)
    ) u_dut_b (
        .clk_i          (clk),
        .rst_ni         (b_rst_n),
        .instr_req_i    (b_req),
        .instr_addr_i   (b_addr),
        .instr_gnt_o    (b_gnt),
        .instr_rvalid_o (b_rvalid),
        .instr_rdata_o  (b_rdata),
        .instr_err_o    (b_err),
        .stall_i        (b_stall),
        .load_we_i      (b_we),
        .load_addr_i    (b_laddr),
        .load_wdata_i   (b_wdata),
        .busy_o         (b_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] prog [4];

    // b table: req, gnt, rvalid, busy per cycle
    logic [3:0] btab [9];

    initial begin
        prog[0] = 32'h00000013;
        prog[1] = 32'h00100093;
        prog[2] = 32'h00200113;
        prog[3] = 32'h00300193;
        btab[0] = 4'b1100; btab[1] = 4'b1101; btab[2] = 4'b1001;
        btab[3] = 4'b1111; btab[4] = 4'b1111; btab[5] = 4'b0001;
        btab[6] = 4'b0011; btab[7] = 4'b0011; btab[8] = 4'b0000;

        a_rst_n = 1'b0; a_req = 1'b0; a_addr = '0; a_stall = 1'b0;
        a_we = 1'b0; a_laddr = '0; a_wdata = '0;
        b_rst_n = 1'b0; b_req = 1'b0; b_addr = '0; b_stall = 1'b0;
        b_we = 1'b0; b_laddr = '0; b_wdata = '0;

        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_a_err", 32'(a_err), 32'd0);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // preload words 0..3 on both, word 5 = 0 on a
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_we = 1'b1; b_we = (i < 4);
            a_laddr = (i < 4) ? 10'(i) : 10'd5;
            b_laddr = 10'(i);
            a_wdata = (i < 4) ? prog[i] : 32'h0;
            b_wdata = (i < 4) ? prog[i] : 32'h0;
        end
        @(negedge clk);
        a_we = 1'b0; b_we = 1'b0;

        // back-to-back fetch on a
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a_req  = (k < 4);
            a_addr = 32'(k * 4);
            #1;
            check($sformatf("b2b_gnt%0d", k), 32'(a_gnt), 32'(k < 4));
            check($sformatf("b2b_rv%0d", k), 32'(a_rvalid),
                  32'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) begin
                check($sformatf("b2b_data%0d", k), a_rdata, prog[k-1]);
                check($sformatf("b2b_err%0d", k), 32'(a_err), 32'd0);
            end
        end
        check("b2b_busy_end", 32'(a_busy), 32'd0);

        // error responses
        @(negedge clk);
        a_req = 1'b1; a_addr = 32'h0000_1000;
        #1 check("oor_gnt", 32'(a_gnt), 32'd1);
        @(negedge clk);
        a_addr = 32'h0000_0002;
        #1;
        check("oor_rv", 32'(a_rvalid), 32'd1);
        check("oor_err", 32'(a_err), 32'd1);
        check("oor_data", a_rdata, 32'd0);
        @(negedge clk);
        a_req = 1'b0;
        #1;
        check("mis_rv", 32'(a_rvalid), 32'd1);
        check("mis_err", 32'(a_err), 32'd1);
        check("mis_data", a_rdata, 32'd0);

        // stall
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a_req = 1'b1; a_stall = 1'b1; a_addr = 32'h8;
            #1;
            check($sformatf("stall_gnt%0d", k), 32'(a_gnt), 32'd0);
            check($sformatf("stall_rv%0d", k), 32'(a_rvalid), 32'd0);
        end
        @(negedge clk);
        a_stall = 1'b0;
        #1;
        check("unstall_gnt", 32'(a_gnt), 32'd1);
        check("unstall_rv0", 32'(a_rvalid), 32'd0);
        @(negedge clk);
        a_req = 1'b0;
        #1;
        check("unstall_rv1", 32'(a_rvalid), 32'd1);
        check("unstall_data", a_rdata, prog[2]);

        // preload collision: read-before-write
        @(negedge clk);
        a_req = 1'b1; a_addr = 32'h14;
        a_we = 1'b1; a_laddr = 10'd5; a_wdata = 32'hDEADBEEF;
        #1 check("col_gnt", 32'(a_gnt), 32'd1);
        @(negedge clk);
        a_we = 1'b0;
        #1;
        check("col_old_rv", 32'(a_rvalid), 32'd1);
        check("col_old", a_rdata, 32'h0);
        @(negedge clk);
        a_req = 1'b0;
        #1;
        check("col_new_rv", 32'(a_rvalid), 32'd1);
        check("col_new", a_rdata, 32'hDEADBEEF);

        // b: latency 3 with two outstanding
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            b_req  = btab[k][3];
            b_addr = 32'hC;
            #1;
            check($sformatf("lat3_gnt%0d", k), 32'(b_gnt), 32'(btab[k][2]));
            check($sformatf("lat3_rv%0d", k), 32'(b_rvalid),
                  32'(btab[k][1]));
            check($sformatf("lat3_busy%0d", k), 32'(b_busy),
                  32'(btab[k][0]));
            if (btab[k][1]) begin
                check($sformatf("lat3_data%0d", k), b_rdata, prog[3]);
            end
        end

        // b: reset with two in flight
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            b_req = 1'b1; b_addr = 32'h0;
            #1 check($sformatf("rstmid_gnt%0d", k), 32'(b_gnt), 32'd1);
        end
        @(negedge clk);
        b_req = 1'b0; b_rst_n = 1'b0;
        #1;
        check("rstmid_rv", 32'(b_rvalid), 32'd0);
        check("rstmid_busy", 32'(b_busy), 32'd0);
        @(negedge clk);
        b_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("rstmid_norv%0d", k), 32'(b_rvalid), 32'd0);
            check($sformatf("rstmid_idle%0d", k), 32'(b_busy), 32'd0);
        end
        @(negedge clk);
        b_req = 1'b1; b_addr = 32'h8;
        #1 check("rstmid_regnt", 32'(b_gnt), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            b_req = 1'b0;
            #1 check($sformatf("rstmid_rerv%0d", k), 32'(b_rvalid),
                     32'(k == 3));
        end
        check("rstmid_redata", b_rdata, prog[2]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
